washing_machine_ctrl: RTL and testbench

//  Programmable wash-cycle controller; successor to the fixed 8-state sequencer. Adds
//  per-phase timers, level-sensed fill with timeout fault, N configurable rinses, wash

---
 rtl/washing_machine_ctrl_if.sv | 31 +++
 rtl/washing_machine_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_washing_machine_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/washing_machine_ctrl_if.sv
// Signal bundle between the wash-cycle controller and the appliance it drives:
// operator/sensor inputs toward the controller, valve/motor/status outputs back.
interface washing_machine_ctrl_if #(
  parameter int RC_W = 2
);
  logic            power;
  logic            door;
  logic            start;
  logic [1:0]      mode;
  logic [RC_W-1:0] rinse_count;
  logic            level_full;
  logic [1:0]      water;
  logic [1:0]      motor;
  logic [3:0]      state;
  logic            door_lock;
  logic            paused;
  logic            done;
  logic            fault;

  // start is a single-cycle request with no ready back: it is taken only while state
  // reads IDLE and door is 0; acceptance shows as state reading WASH_FILL one cycle later.
  modport master (
    output power, door, start, mode, rinse_count, level_full,
    input  water, motor, state, door_lock, paused, done, fault
  );

  modport slave (
    input  power, door, start, mode, rinse_count, level_full,
    output water, motor, state, door_lock, paused, done, fault
  );
endinterface

// File: rtl/washing_machine_ctrl.sv
// Programmable wash-cycle controller: timed fill/agitate/spin phases, N rinses,
// door pause/resume with spin lock, and a fill-timeout fault. All outputs registered.
module washing_machine_ctrl #(
  parameter int TIMER_W       = 16,
  parameter int AGITATE_TICKS = 100,
  parameter int SPIN_TICKS    = 50,
  parameter int FILL_TIMEOUT  = 200,
  parameter int RC_W          = 2
) (
  input  logic                  clkorig,
  input  logic                  rst,
  washing_machine_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    ST_OFF           = 4'd0,
    ST_IDLE          = 4'd1,
    ST_WASH_FILL     = 4'd2,
    ST_WASH_AGITATE  = 4'd3,
    ST_WASH_SPIN     = 4'd4,
    ST_RINSE_FILL    = 4'd5,
    ST_RINSE_AGITATE = 4'd6,
    ST_RINSE_SPIN    = 4'd7,
    ST_PAUSE         = 4'd8,
    ST_DONE          = 4'd9,
    ST_FAULT         = 4'd10
  } state_e;

  // A phase ends on the cycle its timer shows TICKS-1, so it occupies exactly TICKS cycles.
  localparam logic [TIMER_W-1:0] AGITATE_LAST = TIMER_W'(AGITATE_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPIN_LAST    = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [TIMER_W-1:0] FILL_LAST    = TIMER_W'(FILL_TIMEOUT - 1);

  state_e             state_q, state_d;
  state_e             saved_q, saved_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RC_W-1:0]    rinse_q, rinse_d;
  logic [RC_W-1:0]    count_q, count_d;
  logic [RC_W-1:0]    rinse_inc;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         water_q, water_d;
  logic [1:0]         motor_q, motor_d;
  logic               lock_q, lock_d;
  logic               paused_q, paused_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;

  function automatic logic can_pause(input state_e s);
    logic r;
    r = (s == ST_WASH_FILL) || (s == ST_WASH_AGITATE) ||
        (s == ST_RINSE_FILL) || (s == ST_RINSE_AGITATE);
    return r;
  endfunction

  function automatic logic [1:0] wash_water(input logic [1:0] m);
    logic [1:0] w;
    case (m)
      2'd0:    w = 2'b11;
      2'd1:    w = 2'b10;
      default: w = 2'b01;
    endcase
    return w;
  endfunction

  assign rinse_inc = rinse_q + 1'b1;

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    timer_d = timer_q;
    rinse_d = rinse_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (!bus.power) begin
      state_d = ST_OFF;
      saved_d = ST_OFF;
      timer_d = '0;
      rinse_d = '0;
    end else if (state_q == ST_FAULT) begin
      state_d = ST_FAULT;
    end else if (bus.door && can_pause(state_q)) begin
      // Timer is frozen here; on resume the phase continues from the same count.
      state_d = ST_PAUSE;
      saved_d = state_q;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE: begin
          if (bus.start && !bus.door) begin
            state_d = ST_WASH_FILL;
            mode_d  = bus.mode;
            count_d = bus.rinse_count;
            rinse_d = '0;
            timer_d = '0;
          end
        end
        ST_WASH_FILL, ST_RINSE_FILL: begin
          if (bus.level_full) begin
            if (state_q == ST_WASH_FILL) state_d = ST_WASH_AGITATE;
            else                         state_d = ST_RINSE_AGITATE;
            timer_d = '0;
          end else if (timer_q == FILL_LAST) begin
            state_d = ST_FAULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WASH_AGITATE, ST_RINSE_AGITATE: begin
          if (timer_q == AGITATE_LAST) begin
            if (state_q == ST_WASH_AGITATE) state_d = ST_WASH_SPIN;
            else                            state_d = ST_RINSE_SPIN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WASH_SPIN: begin
          if (timer_q == SPIN_LAST) begin
            if (count_q == '0) state_d = ST_DONE;
            else               state_d = ST_RINSE_FILL;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RINSE_SPIN: begin
          if (timer_q == SPIN_LAST) begin
            rinse_d = rinse_inc;
            if (rinse_inc == count_q) state_d = ST_DONE;
            else                      state_d = ST_RINSE_FILL;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!bus.door) state_d = saved_q;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rinse_d = '0;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_comb begin
    water_d  = 2'b00;
    motor_d  = 2'b00;
    lock_d   = 1'b0;
    paused_d = 1'b0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      ST_WASH_FILL:     water_d = wash_water(mode_d);
      ST_WASH_AGITATE: begin
        water_d = wash_water(mode_d);
        motor_d = 2'b01;
      end
      ST_WASH_SPIN: begin
        motor_d = 2'b10;
        lock_d  = 1'b1;
      end
      ST_RINSE_FILL:    water_d = 2'b01;
      ST_RINSE_AGITATE: begin
        water_d = 2'b01;
        motor_d = 2'b01;
      end
      ST_RINSE_SPIN: begin
        motor_d = 2'b10;
        lock_d  = 1'b1;
      end
      ST_PAUSE:         paused_d = 1'b1;
      ST_DONE:          done_d   = 1'b1;
      ST_FAULT:         fault_d  = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge clkorig) begin
    if (rst) begin
      state_q  <= ST_OFF;
      saved_q  <= ST_OFF;
      timer_q  <= '0;
      rinse_q  <= '0;
      count_q  <= '0;
      mode_q   <= 2'b00;
      water_q  <= 2'b00;
      motor_q  <= 2'b00;
      lock_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      timer_q  <= timer_d;
      rinse_q  <= rinse_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      water_q  <= water_d;
      motor_q  <= motor_d;
      lock_q   <= lock_d;
      paused_q <= paused_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.water     = water_q;
  assign bus.motor     = motor_q;
  assign bus.door_lock = lock_q;
  assign bus.paused    = paused_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Bench for washing_machine_ctrl: directed program scenarios plus random operation,
// every cycle compared against a phase-countdown reference model.
module tb_washing_machine_ctrl;
  localparam int AG   = 100;
  localparam int SP   = 50;
  localparam int FT   = 200;
  localparam int RC_W = 2;

  localparam int S_OFF = 0, S_IDLE = 1, S_WASH_FILL = 2, S_WASH_AGITATE = 3, S_WASH_SPIN = 4;
  localparam int S_RINSE_FILL = 5, S_RINSE_AGITATE = 6, S_RINSE_SPIN = 7, S_PAUSE = 8;
  localparam int S_DONE = 9, S_FAULT = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  washing_machine_ctrl_if #(.RC_W(RC_W)) bus ();

  washing_machine_ctrl #(
    .TIMER_W(16), .AGITATE_TICKS(AG), .SPIN_TICKS(SP), .FILL_TIMEOUT(FT), .RC_W(RC_W)
  ) dut (
    .clkorig(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cnt[16];
  logic [1:0] wash_water_seen;
  logic [1:0] rinse_water_seen;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {bus.water, bus.motor, bus.door_lock, bus.paused, bus.done, bus.fault};
  endfunction

  // reference model: phase + cycles left in timed phase + fill cycles used + rinses still owed
  int         m_state = S_OFF;
  int         m_resume = S_OFF;
  int         m_left = 0;
  int         m_fill = 0;
  int         m_rinses_left = 0;
  logic [1:0] m_mode = 2'b00;
  logic [11:0] exp_q[$];

  function automatic logic [7:0] exp_outs(input int st, input logic [1:0] md);
    logic [1:0] w;
    logic [1:0] mo;
    w  = 2'b00;
    mo = 2'b00;
    if (st == S_WASH_FILL || st == S_WASH_AGITATE) w = (md == 2'd0) ? 2'b11 : (md == 2'd1) ? 2'b10 : 2'b01;
    else if (st == S_RINSE_FILL || st == S_RINSE_AGITATE) w = 2'b01;
    if (st == S_WASH_AGITATE || st == S_RINSE_AGITATE) mo = 2'b01;
    else if (st == S_WASH_SPIN || st == S_RINSE_SPIN) mo = 2'b10;
    return {w, mo, (st == S_WASH_SPIN || st == S_RINSE_SPIN), (st == S_PAUSE), (st == S_DONE), (st == S_FAULT)};
  endfunction

  function automatic void enter(input int s);
    m_state = s;
    m_fill  = 0;
    m_left  = (s == S_WASH_AGITATE || s == S_RINSE_AGITATE) ? AG :
              (s == S_WASH_SPIN || s == S_RINSE_SPIN) ? SP : 0;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_state = S_OFF; m_resume = S_OFF; m_left = 0; m_fill = 0; m_rinses_left = 0; m_mode = 2'b00;
    end else if (!bus.power) begin
      m_state = S_OFF; m_resume = S_OFF;
    end else if (m_state == S_FAULT) begin
      m_state = S_FAULT;
    end else if (bus.door && (m_state == S_WASH_FILL || m_state == S_WASH_AGITATE ||
                              m_state == S_RINSE_FILL || m_state == S_RINSE_AGITATE)) begin
      m_resume = m_state;
      m_state  = S_PAUSE;
    end else begin
      case (m_state)
        S_OFF:  m_state = S_IDLE;
        S_IDLE: if (bus.start && !bus.door) begin
          m_mode = bus.mode;
          m_rinses_left = int'(bus.rinse_count);
          enter(S_WASH_FILL);
        end
        S_WASH_FILL, S_RINSE_FILL: begin
          if (bus.level_full) enter(m_state == S_WASH_FILL ? S_WASH_AGITATE : S_RINSE_AGITATE);
          else begin
            m_fill++;
            if (m_fill == FT) m_state = S_FAULT;
          end
        end
        S_WASH_AGITATE, S_RINSE_AGITATE: begin
          m_left--;
          if (m_left == 0) enter(m_state == S_WASH_AGITATE ? S_WASH_SPIN : S_RINSE_SPIN);
        end
        S_WASH_SPIN: begin
          m_left--;
          if (m_left == 0) enter(m_rinses_left == 0 ? S_DONE : S_RINSE_FILL);
        end
        S_RINSE_SPIN: begin
          m_left--;
          if (m_left == 0) begin
            m_rinses_left--;
            enter(m_rinses_left == 0 ? S_DONE : S_RINSE_FILL);
          end
        end
        S_PAUSE: if (!bus.door) m_state = m_resume;
        S_DONE:  m_state = S_IDLE;
        default: m_state = S_OFF;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    model_step();
    exp_q.push_back({4'(m_state), exp_outs(m_state, m_mode)});
  end

  // scoreboard: every cycle's registered outputs against the model
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      check_eq("state", 16'(bus.state), 16'(e[11:8]));
      check_eq("outputs", 16'(dut_outs()), 16'(e[7:0]));
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [1:0] md, input int rc);
    @(negedge clk);
    bus.mode = md;
    bus.rinse_count = RC_W'(rc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_program(input logic [1:0] md, input int rc, input int fill_delay,
                             input int door_at, input int door_len, input bit spin_door,
                             input int budget);
    int st, k, fill_seen, wag_seen, door_left;
    bit door_done;
    foreach (cnt[i]) cnt[i] = 0;
    pulse_start(md, rc);
    k = 0; fill_seen = 0; wag_seen = 0; door_left = 0; door_done = 1'b0;
    while (k < budget) begin
      st = int'(bus.state);
      cnt[st]++;
      if (st == S_WASH_AGITATE) begin
        wag_seen++;
        wash_water_seen = bus.water;
      end
      if (st == S_RINSE_AGITATE) rinse_water_seen = bus.water;
      if (st == S_WASH_FILL || st == S_RINSE_FILL) begin
        fill_seen++;
        bus.level_full = (fill_seen > fill_delay);
      end else begin
        fill_seen = 0;
        bus.level_full = 1'b0;
      end
      if (door_left > 0) begin
        door_left--;
        if (door_left == 0) bus.door = 1'b0;
      end else if (door_at >= 0 && !door_done && st == S_WASH_AGITATE && wag_seen == door_at + 1) begin
        bus.door = 1'b1;
        door_left = door_len;
        door_done = 1'b1;
      end else if (spin_door) begin
        bus.door = (st == S_WASH_SPIN || st == S_RINSE_SPIN);
      end
      if (st == S_IDLE) break;
      @(negedge clk);
      k++;
    end
    bus.level_full = 1'b0;
    bus.door = 1'b0;
    check_eq("program_ends_idle", 16'(bus.state), 16'(S_IDLE));
  endtask

  task automatic advance_until(input int target, input int n, input bit fill_ok, input int budget);
    int seen, k, st;
    seen = 0; k = 0;
    while (k < budget && seen < n) begin
      @(negedge clk);
      k++;
      st = int'(bus.state);
      bus.level_full = fill_ok && (st == S_WASH_FILL || st == S_RINSE_FILL) && ($urandom_range(0, 3) == 0);
      if (st == target) seen++;
    end
    bus.level_full = 1'b0;
    check_eq("reach_state", 16'(seen), 16'(n));
  endtask

  initial begin
    int fill_n, k, d;
    rst = 1'b1;
    bus.power = 1'b0; bus.door = 1'b0; bus.start = 1'b0;
    bus.mode = 2'b00; bus.rinse_count = '0; bus.level_full = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 16'(bus.state), 16'(S_OFF));
    check_eq("reset_outputs", 16'(dut_outs()), 16'(0));
    rst = 1'b0;
    bus.power = 1'b1;
    @(negedge clk);
    check_eq("power_on_idle", 16'(bus.state), 16'(S_IDLE));

    // full program, one rinse, fill satisfied after 3 cycles
    run_program(2'd0, 1, 3, -1, 0, 1'b0, 2000);
    check_eq("wash_fill_len", 16'(cnt[S_WASH_FILL]), 16'(4));
    check_eq("wash_agitate_len", 16'(cnt[S_WASH_AGITATE]), 16'(AG));
    check_eq("wash_spin_len", 16'(cnt[S_WASH_SPIN]), 16'(SP));
    check_eq("rinse_agitate_len", 16'(cnt[S_RINSE_AGITATE]), 16'(AG));
    check_eq("rinse_spin_len", 16'(cnt[S_RINSE_SPIN]), 16'(SP));
    check_eq("done_len", 16'(cnt[S_DONE]), 16'(1));
    check_eq("wash_water_hot_cold", 16'(wash_water_seen), 16'(2'b11));
    check_eq("rinse_water_cold", 16'(rinse_water_seen), 16'(2'b01));

    // zero rinses, then three rinses
    run_program(2'd1, 0, 1, -1, 0, 1'b0, 2000);
    check_eq("no_rinse_fill", 16'(cnt[S_RINSE_FILL]), 16'(0));
    check_eq("no_rinse_done", 16'(cnt[S_DONE]), 16'(1));
    check_eq("wash_water_hot", 16'(wash_water_seen), 16'(2'b10));
    d = $urandom_range(0, 6);
    run_program(2'($urandom_range(0, 3)), 3, d, -1, 0, 1'b0, 3000);
    check_eq("three_rinse_fill", 16'(cnt[S_RINSE_FILL]), 16'(3 * (d + 1)));
    check_eq("three_rinse_agitate", 16'(cnt[S_RINSE_AGITATE]), 16'(3 * AG));
    check_eq("three_rinse_spin", 16'(cnt[S_RINSE_SPIN]), 16'(3 * SP));

    // door opened at agitate cycle 40 for 10 cycles; door also opened through spin
    run_program(2'd0, 0, 2, 40, 10, 1'b1, 2000);
    check_eq("pause_len", 16'(cnt[S_PAUSE]), 16'(10));
    check_eq("agitate_with_pause", 16'(cnt[S_WASH_AGITATE]), 16'(41 + (AG - 40)));
    check_eq("spin_ignores_door", 16'(cnt[S_WASH_SPIN]), 16'(SP));

    // fill timeout -> sticky fault until power drops
    pulse_start(2'd2, 1);
    fill_n = 0; k = 0;
    while (bus.state == 4'(S_WASH_FILL) && k < 400) begin
      fill_n++;
      @(negedge clk);
      k++;
    end
    check_eq("fault_fill_len", 16'(fill_n), 16'(FT));
    check_eq("fault_state", 16'(bus.state), 16'(S_FAULT));
    check_eq("fault_flag", 16'(bus.fault), 16'(1));
    pulse_start(2'd0, 1);
    check_eq("fault_ignores_start", 16'(bus.state), 16'(S_FAULT));
    bus.power = 1'b0;
    @(negedge clk);
    check_eq("fault_power_off", 16'(bus.state), 16'(S_OFF));
    bus.power = 1'b1;
    @(negedge clk);
    check_eq("fault_power_on", 16'(bus.state), 16'(S_IDLE));

    // power loss mid rinse agitate
    pulse_start(2'd0, 2);
    advance_until(S_RINSE_AGITATE, 20, 1'b1, 2000);
    bus.power = 1'b0;
    @(negedge clk);
    check_eq("power_loss_state", 16'(bus.state), 16'(S_OFF));
    check_eq("power_loss_outputs", 16'(dut_outs()), 16'(0));
    bus.power = 1'b1;
    @(negedge clk);

    // synchronous reset mid wash agitate
    pulse_start(2'd1, 1);
    advance_until(S_WASH_AGITATE, 10, 1'b1, 500);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_state", 16'(bus.state), 16'(S_OFF));
    check_eq("rst_mid_outputs", 16'(dut_outs()), 16'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_idle", 16'(bus.state), 16'(S_IDLE));

    // start refused with door open; mode 3 gives cold wash water
    bus.door = 1'b1;
    pulse_start(2'd0, 1);
    check_eq("start_door_open", 16'(bus.state), 16'(S_IDLE));
    bus.door = 1'b0;
    pulse_start(2'd3, 0);
    check_eq("mode3_state", 16'(bus.state), 16'(S_WASH_FILL));
    check_eq("mode3_water", 16'(bus.water), 16'(2'b01));
    advance_until(S_IDLE, 1, 1'b1, 2000);

    // random operation
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 2999) == 0);
      if (!bus.power) bus.power = ($urandom_range(0, 4) == 0);
      else            bus.power = ($urandom_range(0, 799) != 0);
      if (bus.door) bus.door = ($urandom_range(0, 5) != 0);
      else          bus.door = ($urandom_range(0, 59) == 0);
      bus.start       = ($urandom_range(0, 15) == 0);
      bus.mode        = 2'($urandom_range(0, 3));
      bus.rinse_count = RC_W'($urandom_range(0, 3));
      bus.level_full  = ($urandom_range(0, 7) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
